// File: rtl/ctrl_byte_arbiter.sv
// ctrl_byte_arbiter
// Merges two command byte streams (s0: SPI host bridge, s1: boot/preset
// sequencer) into the single in_byte/in_ready/next interface of the
// command controller. Each source has its own byte FIFO. Arbitration is
// command-atomic and round-robin on ties. A watchdog aborts a command that
// stalls mid-stream because its source has run dry.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   s0_byte/valid/ready   source 0 push interface (ready = FIFO not full)
//   s1_byte/valid/ready   source 1 push interface (ready = FIFO not full)
//   out_byte, out_ready   head byte of granted FIFO and its valid, to controller
//   next                  controller consume pulse, pops the granted FIFO
//   ctrl_idle             controller is in its READY state
//   grant                 one-hot granted source, 00 when none
//   ctrl_abort            one-cycle pulse, ORed into the controller reset
//   timeout_err           sticky watchdog flag, cleared by err_clear
module ctrl_byte_arbiter #(
  parameter int unsigned fifo_depth     = 16,
  parameter int unsigned timeout_cycles = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_byte,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_byte,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] out_byte,
  output logic       out_ready,
  input  logic       next,
  input  logic       ctrl_idle,
  output logic [1:0] grant,
  output logic       ctrl_abort,
  output logic       timeout_err,
  input  logic       err_clear
);

  localparam int unsigned AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CW = $clog2(fifo_depth + 1);
  localparam int unsigned TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(fifo_depth);
  localparam logic [TW-1:0] TIMER_LAST = TW'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, LOCKED, ABORT} state_t;

  state_t        state, state_nx;
  logic [1:0]    grant_nx;
  logic          last_grant, last_grant_nx;
  logic          consumed, consumed_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          timeout_err_nx;

  logic [7:0]    mem [2][fifo_depth];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [CW-1:0] count [2];
  logic [7:0]    din [2];
  logic [1:0]    vin, full, empty, push, pop;
  logic          gidx, pop_any, starve, sel;

  always_comb begin
    din[0] = s0_byte;
    din[1] = s1_byte;
    vin    = {s1_valid, s0_valid};
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]  = (count[i] == FULL_COUNT);
      empty[i] = (count[i] == '0);
      push[i]  = vin[i] && !full[i];
    end
  end

  assign s0_ready = !full[0];
  assign s1_ready = !full[1];

  // Granted FIFO index; only meaningful while grant is non-zero.
  assign gidx     = grant[1];
  assign out_byte = (grant != '0) ? mem[gidx][rptr[gidx]] : '0;
  // Once the command has consumed a byte and the controller is back in
  // READY, the next byte belongs to a new command and must wait for
  // re-arbitration.
  assign out_ready = (state == LOCKED) && !empty[gidx] && !(consumed && ctrl_idle);
  assign pop_any   = (state == LOCKED) && next && !empty[gidx];
  assign pop       = {pop_any && gidx, pop_any && !gidx};
  assign starve    = consumed && !ctrl_idle && empty[gidx] && !next;
  // Tie goes to the source that did not win last; otherwise the non-empty one.
  assign sel       = (empty == 2'b00) ? !last_grant : empty[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= 1'b1;
      consumed    <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last_grant  <= last_grant_nx;
      consumed    <= consumed_nx;
      timer       <= timer_nx;
      timeout_err <= timeout_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    last_grant_nx  = last_grant;
    consumed_nx    = consumed || pop_any;
    timer_nx       = timer;
    ctrl_abort     = 1'b0;
    timeout_err_nx = err_clear ? 1'b0 : timeout_err;
    unique case (state)
      IDLE: begin
        if (ctrl_idle && (empty != 2'b11)) begin
          grant_nx      = sel ? 2'b10 : 2'b01;
          last_grant_nx = sel;
          consumed_nx   = 1'b0;
          timer_nx      = '0;
          state_nx      = LOCKED;
        end
      end
      LOCKED: begin
        if (consumed && ctrl_idle) begin
          grant_nx = '0;
          state_nx = IDLE;
        end else if (pop_any) begin
          timer_nx = '0;
        end else if (starve) begin
          if (timer == TIMER_LAST) state_nx = ABORT;
          else                     timer_nx = timer + 1'b1;
        end
      end
      ABORT: begin
        // Offending FIFO keeps its bytes; only the grant is dropped.
        ctrl_abort     = 1'b1;
        timeout_err_nx = 1'b1;
        grant_nx       = '0;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_byte_arbiter.sv
module tb_ctrl_byte_arbiter;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s0_byte, s1_byte, out_byte;
  logic       s0_valid, s1_valid, s0_ready, s1_ready;
  logic       out_ready, next, ctrl_idle, ctrl_abort, timeout_err, err_clear;
  logic [1:0] grant;

  ctrl_byte_arbiter #(.fifo_depth(DEPTH), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset),
    .s0_byte(s0_byte), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_byte(s1_byte), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .out_byte(out_byte), .out_ready(out_ready), .next(next),
    .ctrl_idle(ctrl_idle), .grant(grant), .ctrl_abort(ctrl_abort),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Reference model: per-source byte queues plus command-level arbiter state.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] dlog[$];
  logic [8:0] elog[$];
  bit m_locked, m_abort, m_consumed, m_err;
  int m_src, m_last, m_starve;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int msize(input int s);
    if (s < 0) return 0;
    return (s == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic [7:0] mfront(input int s);
    return (s == 1) ? q1[0] : q0[0];
  endfunction

  function automatic bit m_ordy();
    return m_locked && (msize(m_src) > 0) && !(m_consumed && ctrl_idle);
  endfunction

  task automatic m_reset();
    q0.delete(); q1.delete();
    m_locked = 0; m_abort = 0; m_consumed = 0; m_err = 0;
    m_src = -1; m_last = 1; m_starve = 0;
  endtask

  task automatic m_step();
    bit p0, p1, pop;
    int ps;
    p0  = s0_valid && (q0.size() < DEPTH);
    p1  = s1_valid && (q1.size() < DEPTH);
    pop = m_locked && next && (msize(m_src) > 0);
    ps  = m_src;
    if (err_clear) m_err = 0;
    if (m_abort) begin
      m_abort = 0; m_err = 1; m_src = -1;
    end else if (m_locked) begin
      if (m_consumed && ctrl_idle) begin
        m_locked = 0; m_src = -1;
      end else if (pop) begin
        m_starve = 0;
      end else if (m_consumed && !ctrl_idle && msize(m_src) == 0 && !next) begin
        if (m_starve == TO - 1) begin m_locked = 0; m_abort = 1; end
        else m_starve++;
      end
    end else if (ctrl_idle && (q0.size() > 0 || q1.size() > 0)) begin
      if (q0.size() > 0 && q1.size() > 0) m_src = 1 - m_last;
      else m_src = (q0.size() > 0) ? 0 : 1;
      m_last = m_src; m_consumed = 0; m_starve = 0; m_locked = 1;
    end
    if (pop) begin
      m_consumed = 1;
      if (ps == 1) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (p0) q0.push_back(s0_byte);
    if (p1) q1.push_back(s1_byte);
  endtask

  task automatic check_all();
    chk("grant", grant, (m_src < 0) ? 0 : (1 << m_src));
    chk("out_ready", out_ready, m_ordy());
    chk("s0_ready", s0_ready, q0.size() < DEPTH);
    chk("s1_ready", s1_ready, q1.size() < DEPTH);
    chk("ctrl_abort", ctrl_abort, m_abort);
    chk("timeout_err", timeout_err, m_err);
    if (m_src < 0) chk("out_byte_none", out_byte, 0);
    else if (msize(m_src) > 0) chk("out_byte", out_byte, mfront(m_src));
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cyc();
    #1;
    check_all();
    if (next && m_ordy()) dlog.push_back({grant[1], out_byte});
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic serve(input int n);
    int got, budget;
    got = 0; budget = 0;
    while (got < n && budget < 100) begin
      next = m_ordy();
      cyc();
      if (next) begin got++; ctrl_idle = 1'b0; end
      next = 1'b0;
      budget++;
    end
    chk("serve_count", got, n);
  endtask

  task automatic release_cmd();
    ctrl_idle = 1'b1;
    cyc();
  endtask

  task automatic push_seq(input bit src, input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      if (src) begin s1_valid = 1'b1; s1_byte = start + 8'(i); end
      else     begin s0_valid = 1'b1; s0_byte = start + 8'(i); end
      cyc();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic push_both(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      s0_valid = 1'b1; s0_byte = a + 8'(i);
      s1_valid = 1'b1; s1_byte = b + 8'(i);
      cyc();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic exp_bytes(input bit src, input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) elog.push_back({src, start + 8'(i)});
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, dlog.size(), elog.size());
    for (int i = 0; i < elog.size() && i < dlog.size(); i++) chk(tag, dlog[i], elog[i]);
    dlog.delete(); elog.delete();
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_out_ready"}, out_ready, 0);
    chk({tag, "_s0_ready"}, s0_ready, 1);
    chk({tag, "_s1_ready"}, s1_ready, 1);
    chk({tag, "_out_byte"}, out_byte, 0);
    chk({tag, "_abort"}, ctrl_abort, 0);
    chk({tag, "_err"}, timeout_err, 0);
    m_reset();
    s0_valid = 1'b0; s1_valid = 1'b0; next = 1'b0; err_clear = 1'b0;
    dlog.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, k, got, rem, waitc;
    bit done, pnow, abnow, acc;

    reset = 1'b1;
    s0_byte = '0; s1_byte = '0; s0_valid = 1'b0; s1_valid = 1'b0;
    next = 1'b0; ctrl_idle = 1'b1; err_clear = 1'b0;
    m_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_abort", ctrl_abort, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_s0_ready", s0_ready, 1);
    chk("rst_s1_ready", s1_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Contention A: tie after reset goes to source 0
    ctrl_idle = 1'b0;
    push_both(8'h10, 8'h20, 3);
    ctrl_idle = 1'b1;
    serve(3);
    repeat (2) cyc();
    ctrl_idle = 1'b1;
    serve(3);
    repeat (2) cyc();
    release_cmd();
    exp_bytes(0, 8'h10, 3); exp_bytes(1, 8'h20, 3);
    cmp_log("contention_a");

    // Single source write-reg command
    s0_valid = 1'b1;
    s0_byte = 8'h01; cyc();
    s0_byte = 8'h00; cyc();
    s0_byte = 8'hAA; cyc();
    s0_byte = 8'hBB; cyc();
    s0_valid = 1'b0;
    serve(4);
    repeat (6) cyc();
    release_cmd();
    #1 chk("single_release_grant", grant, 0);
    elog.push_back({1'b0, 8'h01}); elog.push_back({1'b0, 8'h00});
    elog.push_back({1'b0, 8'hAA}); elog.push_back({1'b0, 8'hBB});
    cmp_log("single");

    // Contention B: source 0 won last, so source 1 goes first
    ctrl_idle = 1'b0;
    push_both(8'h50, 8'h60, 3);
    ctrl_idle = 1'b1;
    serve(3);
    repeat (2) cyc();
    ctrl_idle = 1'b1;
    serve(3);
    repeat (2) cyc();
    release_cmd();
    exp_bytes(1, 8'h60, 3); exp_bytes(0, 8'h50, 3);
    cmp_log("contention_b");

    // Release gating with a second queued command on the same source
    ctrl_idle = 1'b0;
    push_seq(0, 8'h30, 4);
    ctrl_idle = 1'b1;
    serve(2);
    ctrl_idle = 1'b1;
    #1;
    chk("gate_rel_out_ready", out_ready, 0);
    chk("gate_rel_grant", grant, 2'b01);
    cyc();
    #1;
    chk("gate_idle_grant", grant, 0);
    chk("gate_idle_out_ready", out_ready, 0);
    cyc();
    #1;
    chk("gate_regrant", grant, 2'b01);
    chk("gate_regrant_out_ready", out_ready, 1);
    serve(2);
    release_cmd();
    exp_bytes(0, 8'h30, 4);
    cmp_log("gating");

    // Watchdog: one byte of a longer command, then the source stops
    push_seq(1, 8'h40, 1);
    serve(1);
    n = 0;
    while (n < 20) begin
      #1;
      if (ctrl_abort === 1'b1) break;
      cyc();
      n++;
    end
    chk("wd_starved_cycles", n, 8);
    chk("wd_abort_pulse", ctrl_abort, 1);
    ctrl_idle = 1'b1;
    cyc();
    #1;
    chk("wd_err_set", timeout_err, 1);
    chk("wd_grant_dropped", grant, 0);
    chk("wd_abort_one_cycle", ctrl_abort, 0);
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    #1 chk("wd_err_cleared", timeout_err, 0);
    dlog.delete();

    // FIFO full and 20-byte stream across pointer wrap
    ctrl_idle = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      s0_valid = 1'b1; s0_byte = 8'(k);
      acc = q0.size() < DEPTH;
      cyc();
      if (acc) k++;
    end
    #1;
    chk("full_s0_ready", s0_ready, 0);
    chk("full_accepted", k, 4);
    ctrl_idle = 1'b1;
    got = 0;
    for (int b = 0; b < 200 && got < 20; b++) begin
      s0_valid = (k < 20); s0_byte = 8'(k);
      next = m_ordy();
      acc = s0_valid && (q0.size() < DEPTH);
      cyc();
      if (acc) k++;
      if (next) begin got++; ctrl_idle = 1'b0; end
      next = 1'b0;
    end
    s0_valid = 1'b0;
    chk("stream_count", got, 20);
    release_cmd();
    exp_bytes(0, 8'h00, 20);
    cmp_log("stream");

    // Randomized traffic on both sources with a random-length controller
    ctrl_idle = 1'b1; done = 0; rem = 0; waitc = 0;
    for (int i = 0; i < 400; i++) begin
      s0_valid = 1'($urandom % 2); s0_byte = 8'($urandom);
      s1_valid = 1'($urandom % 2); s1_byte = 8'($urandom);
      err_clear = (($urandom % 16) == 0);
      next = !done && m_ordy() && (($urandom % 4) != 0);
      pnow = next; abnow = m_abort;
      cyc();
      next = 1'b0;
      if (abnow) begin
        ctrl_idle = 1'b1; done = 0;
      end else if (pnow) begin
        if (ctrl_idle) begin ctrl_idle = 1'b0; rem = $urandom_range(0, 3); end
        else rem--;
        if (rem == 0) begin done = 1; waitc = $urandom_range(0, 3); end
      end else if (done) begin
        if (waitc == 0) begin ctrl_idle = 1'b1; done = 0; end
        else waitc--;
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0; err_clear = 1'b0;
    dlog.delete();
    async_reset_check("rst_clean");

    // Async reset in the middle of a command
    ctrl_idle = 1'b1;
    push_seq(0, 8'h70, 3);
    serve(1);
    async_reset_check("rst_mid");
    ctrl_idle = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
